// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: clocked sweep of every input vector of a gate under test,
// comparing each settled output against an expected truth table.  Rev 1.0
`default_nettype none

module gate_test_sequencer #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 3,
    parameter logic [2**N_IN-1:0]  EXP_TT = 4'b0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [2**N_IN-1:0]   fail_vec
);

    localparam int              NVEC     = 2**N_IN;
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NVEC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [NVEC-1:0]   fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dut_in_q <= dut_in_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
        end
    end

    // Case inequality so that a floating or unknown gate output never passes.
    assign mismatch = (dut_out !== EXP_TT[idx_q]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dut_in_d = dut_in_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                dut_in_d = idx_q;
                cnt_d    = CW'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d         = err_q + (N_IN+1)'(1);
                    fail_d[idx_q] = 1'b1;
                end
                // Verdict is taken from the count including this last sample,
                // so pass is already valid alongside the done pulse.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: drives a NOR-configured and an inverter-configured sequencer
// against behavioural gates and checks every cycle against a sweep-timing model.
`default_nettype none

module tb_gate_test_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // NOR instance (defaults) and inverter instance
    logic       nor_start = 1'b0, inv_start = 1'b0;
    int         nor_mode  = 0,    inv_mode  = 0;
    logic [1:0] nor_in;
    logic [0:0] inv_in;
    logic       nor_out, inv_out;
    logic       nor_busy, nor_done, nor_pass, inv_busy, inv_done, inv_pass;
    logic [2:0] nor_err;
    logic [1:0] inv_err;
    logic [3:0] nor_fail;
    logic [1:0] inv_fail;

    gate_test_sequencer #(.N_IN(2), .SETTLE(3), .EXP_TT(4'b0001)) u_nor (
        .clk(clk), .rst(rst), .start(nor_start), .dut_in(nor_in), .dut_out(nor_out),
        .busy(nor_busy), .done(nor_done), .pass(nor_pass),
        .err_count(nor_err), .fail_vec(nor_fail)
    );

    gate_test_sequencer #(.N_IN(1), .SETTLE(3), .EXP_TT(2'b01)) u_inv (
        .clk(clk), .rst(rst), .start(inv_start), .dut_in(inv_in), .dut_out(inv_out),
        .busy(inv_busy), .done(inv_done), .pass(inv_pass),
        .err_count(inv_err), .fail_vec(inv_fail)
    );

    // Gates: mode 0 correct, 1 output stuck 0, 2 output stuck 1 (NOR);
    // inverter mode 1 has its pull-up missing, so the output floats for input 0.
    always_comb begin
        nor_out = (nor_mode == 0) ? ~|nor_in : (nor_mode == 2);
        if (inv_in[0])          inv_out = 1'b0;
        else if (inv_mode == 0) inv_out = 1'b1;
        else                    inv_out = 1'bz;
    end

    function automatic int nor_mask(input int mode);
        int m = 0;
        for (int v = 0; v < 4; v++) begin
            bit g = (mode == 0) ? (v == 0) : (mode == 2);
            if (g != (v == 0)) m |= (1 << v);
        end
        return m;
    endfunction

    function automatic int inv_mask(input int mode);
        return (mode == 0) ? 0 : 1;
    endfunction

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  err;
        logic [15:0] fail;
        logic [3:0]  din;
    } exp_t;

    // k = cycles since accepted start (1 = first cycle after the start edge),
    // 0 = nothing since reset, k > T = idle after a completed sweep.
    function automatic exp_t model_out(input int n, input int s, input int k,
                                       input int mask, input int held);
        int   v = 1 << n;
        int   p = s + 2;
        int   t = v * p + 1;
        int   ns;
        int   vi;
        exp_t e = '0;
        if (k == 0) return e;
        if (k > t) begin
            e.din  = 4'(v - 1);
            e.fail = 16'(mask);
            e.err  = 5'($countones(mask));
            e.pass = (mask == 0);
            return e;
        end
        e.busy = 1'b1;
        e.done = (k == t);
        e.pass = (k == t) && (mask == 0);
        ns = (k - 1) / p;
        if (ns > v) ns = v;
        e.fail = 16'(mask & ((1 << ns) - 1));
        e.err  = 5'($countones(e.fail));
        if (k == 1) begin
            e.din = 4'(held);
        end else begin
            vi = (k - 2) / p;
            if (vi > v - 1) vi = v - 1;
            e.din = 4'(vi);
        end
        return e;
    endfunction

    localparam int T_NOR = 4 * 5 + 1;
    localparam int T_INV = 2 * 5 + 1;

    int k_n = 0, mask_n = 0, held_n = 0;
    int k_i = 0, mask_i = 0, held_i = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_n <= 0; held_n <= 0;
            k_i <= 0; held_i <= 0;
        end else begin
            if (k_n >= 1 && k_n <= T_NOR) k_n <= k_n + 1;
            else if (nor_start) begin
                k_n    <= 1;
                mask_n <= nor_mask(nor_mode);
                if (k_n != 0) held_n <= 3;
            end
            if (k_i >= 1 && k_i <= T_INV) k_i <= k_i + 1;
            else if (inv_start) begin
                k_i    <= 1;
                mask_i <= inv_mask(inv_mode);
                if (k_i != 0) held_i <= 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int ex);
        checks++;
        if (act != ex) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, ex, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t en, ei;
        en = model_out(2, 3, k_n, mask_n, held_n);
        ei = model_out(1, 3, k_i, mask_i, held_i);
        chk("nor_busy", int'(nor_busy), int'(en.busy));
        chk("nor_done", int'(nor_done), int'(en.done));
        chk("nor_pass", int'(nor_pass), int'(en.pass));
        chk("nor_err",  int'(nor_err),  int'(en.err));
        chk("nor_fail", int'(nor_fail), int'(en.fail));
        chk("nor_din",  int'(nor_in),   int'(en.din));
        chk("inv_busy", int'(inv_busy), int'(ei.busy));
        chk("inv_done", int'(inv_done), int'(ei.done));
        chk("inv_pass", int'(inv_pass), int'(ei.pass));
        chk("inv_err",  int'(inv_err),  int'(ei.err));
        chk("inv_fail", int'(inv_fail), int'(ei.fail));
        chk("inv_din",  int'(inv_in),   int'(ei.din));
    end

    // Pulses start for one cycle; returns cycles from start edge to the done
    // pulse. restart_at != 0 re-pulses start at that cycle of the sweep.
    task automatic run_sweep(input bit inv, input int mode, input int restart_at,
                             output int cyc);
        if (inv) inv_mode = mode; else nor_mode = mode;
        @(negedge clk);
        if (inv) inv_start = 1'b1; else nor_start = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 || (restart_at != 0 && cyc == restart_at + 1)) begin
                inv_start = 1'b0; nor_start = 1'b0;
            end
            if (restart_at != 0 && cyc == restart_at) begin
                if (inv) inv_start = 1'b1; else nor_start = 1'b1;
            end
            if (inv ? inv_done : nor_done) break;
            if (cyc > 200) begin
                chk("sweep_timeout", cyc, 0);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(nor_busy), 0);
        chk("rst_err",  int'(nor_err),  0);
        rst = 1'b0;

        run_sweep(1'b0, 0, 0, cyc);
        chk("nor_ok_cycles", cyc, 21);
        chk("nor_ok_pass", int'(nor_pass), 1);
        chk("nor_ok_err",  int'(nor_err),  0);
        chk("nor_ok_fail", int'(nor_fail), 4'b0000);

        run_sweep(1'b0, 1, 0, cyc);
        chk("nor_tie0_pass", int'(nor_pass), 0);
        chk("nor_tie0_err",  int'(nor_err),  1);
        chk("nor_tie0_fail", int'(nor_fail), 4'b0001);

        run_sweep(1'b0, 2, 0, cyc);
        chk("nor_tie1_err",  int'(nor_err),  3);
        chk("nor_tie1_fail", int'(nor_fail), 4'b1110);
        chk("nor_tie1_din",  int'(nor_in),   3);

        run_sweep(1'b1, 0, 0, cyc);
        chk("inv_ok_cycles", cyc, 11);
        chk("inv_ok_pass", int'(inv_pass), 1);
        chk("inv_ok_fail", int'(inv_fail), 2'b00);

        run_sweep(1'b1, 1, 0, cyc);
        chk("inv_nopmos_err",  int'(inv_err),  1);
        chk("inv_nopmos_fail", int'(inv_fail), 2'b01);
        chk("inv_nopmos_pass", int'(inv_pass), 0);

        // start during vector 2 settle is ignored
        run_sweep(1'b0, 0, 12, cyc);
        chk("restart_cycles", cyc, 21);
        chk("restart_pass", int'(nor_pass), 1);

        // start held through DONE: ignored in DONE, accepted in the next IDLE
        nor_start = 1'b1;
        @(negedge clk);
        chk("done_start_idle", int'(nor_busy), 0);
        @(negedge clk);
        chk("done_start_accept", int'(nor_busy), 1);
        nor_start = 1'b0;
        cyc = 1;
        while (!nor_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("second_cycles", cyc, 21);

        // asynchronous reset in vector 1 settle
        nor_mode = 1;
        @(negedge clk); nor_start = 1'b1;
        @(negedge clk); nor_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_err", int'(nor_err), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(nor_busy), 0);
        chk("arst_din",  int'(nor_in),   0);
        chk("arst_err",  int'(nor_err),  0);
        chk("arst_fail", int'(nor_fail), 0);
        @(negedge clk);
        chk("arst_done", int'(nor_done), 0);
        rst = 1'b0;

        run_sweep(1'b0, 0, 0, cyc);
        chk("post_rst_cycles", cyc, 21);
        chk("post_rst_pass", int'(nor_pass), 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
